clock_mode_ctrl: RTL and testbench

- Mode sequencer for the digital clock datapath.
- Takes the four debounced buttons (inc_short, inc_long, set, sw) and produces one-cycle press events and held-press (long-press) events.
- Runs the state machine that enables or freezes the time counter, selects time, alarm or stopwatch for display, and steers hour/minute setting.
- Sits between the debouncers and counter / alarm register / stopwatch / display muxes, all on the master clock.

---
 rtl/clock_mode_ctrl_pkg.sv | 24 ++
 rtl/clock_mode_ctrl_if.sv | 32 +++
 rtl/clock_mode_ctrl_btn_event.sv | 47 ++++
 rtl/clock_mode_ctrl.sv | 143 ++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_mode_ctrl_pkg.sv
// rtl/clock_mode_ctrl_pkg.sv - shared types and constants for the clock mode sequencer
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HR    = 3'd1,
        SET_MIN   = 3'd2,
        ALARM_HR  = 3'd3,
        ALARM_MIN = 3'd4,
        STOPWATCH = 3'd5
    } state_t;

    localparam logic [1:0] MUX_COUNTER = 2'b00;
    localparam logic [1:0] MUX_ALARM   = 2'b10;
    localparam logic [1:0] MUX_SW      = 2'b11;

    localparam logic HR  = 1'b0;
    localparam logic MIN = 1'b1;

    function automatic logic is_setting(input state_t s);
        return (s == SET_HR) || (s == SET_MIN) || (s == ALARM_HR) || (s == ALARM_MIN);
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// rtl/clock_mode_ctrl_if.sv - button inputs and datapath control outputs of the mode sequencer
interface clock_mode_ctrl_if;

    logic       inc_short;
    logic       inc_long;
    logic       set;
    logic       sw;

    logic       counter_enable;
    logic [1:0] mux;
    logic       mux_outmode;
    logic       time_setting_enable;
    logic       time_hr_or_min;
    logic       regalarm_setting_enable;
    logic       regalarm_hr_or_min;
    logic       inc_pulse;
    logic       sw_run;
    logic       sw_clear;

    modport master (
        output inc_short, inc_long, set, sw,
        input  counter_enable, mux, mux_outmode, time_setting_enable, time_hr_or_min,
        input  regalarm_setting_enable, regalarm_hr_or_min, inc_pulse, sw_run, sw_clear
    );

    modport slave (
        input  inc_short, inc_long, set, sw,
        output counter_enable, mux, mux_outmode, time_setting_enable, time_hr_or_min,
        output regalarm_setting_enable, regalarm_hr_or_min, inc_pulse, sw_run, sw_clear
    );

endinterface

// File: rtl/clock_mode_ctrl_btn_event.sv
// rtl/clock_mode_ctrl_btn_event.sv - rising-edge press event and optional held-press event for one button
module btn_event #(
    parameter int LONG_CYCLES = 20000000,
    parameter bit LONG_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_press,
    output logic o_long
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) r_prev <= 1'b0;
        else     r_prev <= i_level;
    end

    assign o_press = i_level & ~r_prev;

    if (LONG_EN) begin : g_long
        localparam int CW = $clog2(LONG_CYCLES);

        logic [CW-1:0] r_cnt;
        logic          r_fired;
        logic          w_at_max;

        assign w_at_max = (r_cnt == CW'(LONG_CYCLES - 1));

        // Counter parks at its top value; r_fired blocks a refire until release.
        always_ff @(posedge clk) begin
            if (rst || !i_level) begin
                r_cnt   <= '0;
                r_fired <= 1'b0;
            end else begin
                if (!w_at_max) r_cnt   <= r_cnt + CW'(1);
                else           r_fired <= 1'b1;
            end
        end

        assign o_long = i_level & w_at_max & ~r_fired;
    end else begin : g_no_long
        assign o_long = 1'b0;
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - mode sequencer steering counter, alarm register, stopwatch and display mux
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int LONG_CYCLES    = 20000000,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    clock_mode_ctrl_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [3:0] w_level;
    logic [3:0] w_press;
    logic [3:0] w_long;

    assign w_level = {bus.sw, bus.set, bus.inc_long, bus.inc_short};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_event #(
            .LONG_CYCLES(LONG_CYCLES),
            .LONG_EN    (gi == 1)
        ) u_btn (
            .clk    (clk),
            .rst    (rst),
            .i_level(w_level[gi]),
            .o_press(w_press[gi]),
            .o_long (w_long[gi])
        );
    end

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_idle;
    logic          r_outmode;
    logic          r_sw_run;
    logic          r_sw_clear;
    logic          r_inc_pulse;

    logic w_ev_set;
    logic w_ev_sw;
    logic w_ev_long;
    logic w_ev_inc;
    logic w_any;
    logic w_setting;
    logic w_timeout;

    // Only the highest-priority event of a cycle acts; the rest are dropped.
    assign w_ev_set  = w_press[2];
    assign w_ev_sw   = w_press[3] & ~w_press[2];
    assign w_ev_long = w_long[1] & ~w_press[3] & ~w_press[2];
    assign w_ev_inc  = w_press[0] & ~w_press[3] & ~w_press[2] & ~w_long[1];
    assign w_any     = |{w_press, w_long};
    assign w_setting = is_setting(r_state);
    assign w_timeout = w_setting & ~w_any & (r_idle == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN: begin
                if      (w_ev_set)  w_next = SET_HR;
                else if (w_ev_sw)   w_next = STOPWATCH;
                else if (w_ev_long) w_next = ALARM_HR;
            end
            SET_HR: begin
                if      (w_ev_set)  w_next = SET_MIN;
                else if (w_timeout) w_next = RUN;
            end
            SET_MIN: begin
                if (w_ev_set || w_timeout) w_next = RUN;
            end
            ALARM_HR: begin
                if      (w_ev_set)  w_next = ALARM_MIN;
                else if (w_timeout) w_next = RUN;
            end
            ALARM_MIN: begin
                if (w_ev_set || w_timeout) w_next = RUN;
            end
            STOPWATCH: begin
                if (w_ev_sw) w_next = RUN;
            end
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle      <= '0;
            r_outmode   <= 1'b0;
            r_sw_run    <= 1'b0;
            r_sw_clear  <= 1'b0;
            r_inc_pulse <= 1'b0;
        end else begin
            if (!w_setting || w_any || (w_next != r_state)) r_idle <= '0;
            else                                            r_idle <= r_idle + TW'(1);

            if (r_state == RUN && w_ev_inc) r_outmode <= ~r_outmode;

            if (r_state == STOPWATCH && w_ev_long)     r_sw_run <= 1'b0;
            else if (r_state == STOPWATCH && w_ev_inc) r_sw_run <= ~r_sw_run;

            r_sw_clear  <= (r_state == STOPWATCH) & w_ev_long;
            r_inc_pulse <= w_setting & w_ev_inc;
        end
    end

    // mux_outmode is masked rather than cleared so RUN gets the pre-setting view back.
    always_comb begin
        bus.counter_enable          = 1'b1;
        bus.mux                     = MUX_COUNTER;
        bus.mux_outmode             = r_outmode;
        bus.time_setting_enable     = 1'b0;
        bus.time_hr_or_min          = HR;
        bus.regalarm_setting_enable = 1'b0;
        bus.regalarm_hr_or_min      = HR;
        bus.inc_pulse               = r_inc_pulse;
        bus.sw_run                  = r_sw_run;
        bus.sw_clear                = r_sw_clear;
        case (r_state)
            SET_HR, SET_MIN: begin
                bus.counter_enable      = 1'b0;
                bus.mux_outmode         = 1'b0;
                bus.time_setting_enable = 1'b1;
                bus.time_hr_or_min      = (r_state == SET_MIN) ? MIN : HR;
            end
            ALARM_HR, ALARM_MIN: begin
                bus.mux                     = MUX_ALARM;
                bus.regalarm_setting_enable = 1'b1;
                bus.regalarm_hr_or_min      = (r_state == ALARM_MIN) ? MIN : HR;
            end
            STOPWATCH: bus.mux = MUX_SW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - directed table plus randomized reference-model bench for clock_mode_ctrl
module tb_clock_mode_ctrl;

    localparam int LONG    = 8;
    localparam int TIMEOUT = 32;

    localparam logic [3:0] B_IS  = 4'b0001;
    localparam logic [3:0] B_IL  = 4'b0010;
    localparam logic [3:0] B_SET = 4'b0100;
    localparam logic [3:0] B_SW  = 4'b1000;

    // {ce, mux[1:0], outmode, tse, thm, rse, rhm, inc_pulse, sw_run, sw_clear}
    localparam logic [10:0] E_RUN  = 11'b1_00_0_00_00_000;
    localparam logic [10:0] E_SHR  = 11'b0_00_0_10_00_000;
    localparam logic [10:0] E_SMIN = 11'b0_00_0_11_00_000;
    localparam logic [10:0] E_AHR  = 11'b1_10_0_00_10_000;
    localparam logic [10:0] E_AMIN = 11'b1_10_0_00_11_000;
    localparam logic [10:0] E_SW   = 11'b1_11_0_00_00_000;
    localparam logic [10:0] F_OM   = 11'b0_00_1_00_00_000;
    localparam logic [10:0] F_IP   = 11'b0_00_0_00_00_100;
    localparam logic [10:0] F_SWR  = 11'b0_00_0_00_00_010;
    localparam logic [10:0] F_SWC  = 11'b0_00_0_00_00_001;

    localparam int S_RUN = 0, S_SHR = 1, S_SMIN = 2, S_AHR = 3, S_AMIN = 4, S_SW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(
        .LONG_CYCLES   (LONG),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int       m_st;
    bit       m_om, m_swr, m_swc, m_ip;
    int       m_hold, m_idle;
    bit [3:0] m_prev;

    typedef struct {
        string       name;
        logic        r;
        logic [3:0]  b;
        int          cycles;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    function automatic logic [10:0] obs();
        return {bus.counter_enable, bus.mux, bus.mux_outmode, bus.time_setting_enable,
                bus.time_hr_or_min, bus.regalarm_setting_enable, bus.regalarm_hr_or_min,
                bus.inc_pulse, bus.sw_run, bus.sw_clear};
    endfunction

    function automatic logic [10:0] m_vec();
        logic [10:0] v;
        case (m_st)
            S_SHR:   v = E_SHR;
            S_SMIN:  v = E_SMIN;
            S_AHR:   v = E_AHR;
            S_AMIN:  v = E_AMIN;
            S_SW:    v = E_SW;
            default: v = E_RUN;
        endcase
        if (m_om && m_st != S_SHR && m_st != S_SMIN) v |= F_OM;
        if (m_ip)  v |= F_IP;
        if (m_swr) v |= F_SWR;
        if (m_swc) v |= F_SWC;
        return v;
    endfunction

    function automatic int set_next(input int s);
        case (s)
            S_RUN:   return S_SHR;
            S_SHR:   return S_SMIN;
            S_AHR:   return S_AMIN;
            S_SMIN, S_AMIN: return S_RUN;
            default: return s;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit [3:0] b);
        bit [3:0] pe;
        bit       lng, any, setting;
        int       nxt;
        if (r) begin
            m_st = S_RUN; m_om = 0; m_swr = 0; m_swc = 0; m_ip = 0;
            m_hold = 0; m_idle = 0; m_prev = 0;
            return;
        end
        pe      = b & ~m_prev;
        m_prev  = b;
        m_hold  = b[1] ? m_hold + 1 : 0;
        lng     = (m_hold == LONG);
        any     = (pe != 0) || lng;
        setting = (m_st >= S_SHR && m_st <= S_AMIN);
        nxt     = m_st;
        m_ip    = 0;
        m_swc   = 0;
        if (pe[2]) nxt = set_next(m_st);
        else if (pe[3]) begin
            if (m_st == S_RUN) nxt = S_SW;
            else if (m_st == S_SW) nxt = S_RUN;
        end else if (lng) begin
            if (m_st == S_RUN) nxt = S_AHR;
            else if (m_st == S_SW) begin m_swc = 1; m_swr = 0; end
        end else if (pe[0]) begin
            if (m_st == S_RUN) m_om = ~m_om;
            else if (m_st == S_SW) m_swr = ~m_swr;
            else m_ip = 1;
        end
        if (setting && !any) begin
            m_idle++;
            if (m_idle == TIMEOUT) nxt = S_RUN;
        end else m_idle = 0;
        if (nxt != m_st) m_idle = 0;
        m_st = nxt;
    endtask

    task automatic step(input logic r, input logic [3:0] b);
        rst           = r;
        bus.inc_short = b[0];
        bus.inc_long  = b[1];
        bus.set       = b[2];
        bus.sw        = b[3];
        @(posedge clk);
        model_step(r, b);
        @(negedge clk);
        check("model", {21'd0, obs()}, {21'd0, m_vec()});
    endtask

    task automatic add(input string n, input logic r, input logic [3:0] b, input int c,
                       input logic [10:0] e);
        tbl.push_back('{n, r, b, c, e});
    endtask

    initial begin
        int          cnt;
        logic        om0;
        logic [3:0]  rb;
        int          quiet;

        bus.inc_short = 0; bus.inc_long = 0; bus.set = 0; bus.sw = 0;

        add("reset",            1, 0,            2,  E_RUN);
        add("idle_run",         0, 0,            3,  E_RUN);
        add("set1_sethr",       0, B_SET,        1,  E_SHR);
        add("hold_sethr",       0, 0,            4,  E_SHR);
        add("set2_setmin",      0, B_SET,        1,  E_SMIN);
        add("hold_setmin",      0, 0,            4,  E_SMIN);
        add("set3_run",         0, B_SET,        1,  E_RUN);
        add("gap",              0, 0,            2,  E_RUN);
        add("enter_sethr",      0, B_SET,        1,  E_SHR);
        add("gap_sethr",        0, 0,            1,  E_SHR);
        add("inc_pulse_first",  0, B_IS,         1,  E_SHR | F_IP);
        add("inc_held",         0, B_IS,         19, E_SHR);
        add("rel_a",            0, 0,            1,  E_SHR);
        add("to_setmin",        0, B_SET,        1,  E_SMIN);
        add("rel_b",            0, 0,            1,  E_SMIN);
        add("to_run",           0, B_SET,        1,  E_RUN);
        add("rel_c",            0, 0,            1,  E_RUN);
        add("outmode_toggle",   0, B_IS,         1,  E_RUN | F_OM);
        add("outmode_held",     0, B_IS,         19, E_RUN | F_OM);
        add("rel_d",            0, 0,            1,  E_RUN | F_OM);
        add("om_forced_sethr",  0, B_SET,        1,  E_SHR);
        add("rel_e",            0, 0,            1,  E_SHR);
        add("om_forced_setmin", 0, B_SET,        1,  E_SMIN);
        add("rel_f",            0, 0,            1,  E_SMIN);
        add("om_restored",      0, B_SET,        1,  E_RUN | F_OM);
        add("rel_g",            0, 0,            1,  E_RUN | F_OM);
        add("om_toggle_back",   0, B_IS,         1,  E_RUN);
        add("rel_h",            0, 0,            1,  E_RUN);
        add("long_7",           0, B_IL,         7,  E_RUN);
        add("long_8_alarm",     0, B_IL,         1,  E_AHR);
        add("long_held",        0, B_IL,         12, E_AHR);
        add("rel_i",            0, 0,            2,  E_AHR);
        add("long_short_hold",  0, B_IL,         5,  E_AHR);
        add("rel_j",            0, 0,            1,  E_AHR);
        add("alarm_inc",        0, B_IS,         1,  E_AHR | F_IP);
        add("rel_k",            0, 0,            1,  E_AHR);
        add("to_amin",          0, B_SET,        1,  E_AMIN);
        add("idle_31",          0, 0,            31, E_AMIN);
        add("timeout_run",      0, 0,            1,  E_RUN);
        add("to_sw",            0, B_SW,         1,  E_SW);
        add("rel_l",            0, 0,            1,  E_SW);
        add("sw_start",         0, B_IS,         1,  E_SW | F_SWR);
        add("rel_m",            0, 0,            1,  E_SW | F_SWR);
        add("sw_long7",         0, B_IL,         7,  E_SW | F_SWR);
        add("sw_clear",         0, B_IL,         1,  E_SW | F_SWC);
        add("sw_clear_once",    0, B_IL,         1,  E_SW);
        add("rel_n",            0, 0,            1,  E_SW);
        add("sw_restart",       0, B_IS,         1,  E_SW | F_SWR);
        add("rel_o",            0, 0,            1,  E_SW | F_SWR);
        add("sw_exit_holds",    0, B_SW,         1,  E_RUN | F_SWR);
        add("rel_p",            0, 0,            1,  E_RUN | F_SWR);
        add("set_beats_sw",     0, B_SET | B_SW, 1,  E_SHR | F_SWR);
        add("rel_q",            0, 0,            1,  E_SHR | F_SWR);
        add("setmin_pre_rst",   0, B_SET,        1,  E_SMIN | F_SWR);
        add("rst_in_setmin",    1, B_SET,        1,  E_RUN);
        add("after_rst",        0, 0,            1,  E_RUN);

        @(negedge clk);
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].cycles; c++) step(tbl[i].r, tbl[i].b);
            check(tbl[i].name, {21'd0, obs()}, {21'd0, tbl[i].exp});
        end

        // Held inc_short: one strobe in a setting state, none in RUN.
        step(1, 0); step(0, 0); step(0, B_SET); step(0, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, B_IS);
            if (bus.inc_pulse) cnt++;
        end
        check("inc_pulse_count_sethr", cnt, 1);
        step(0, 0); step(0, B_SET); step(0, 0); step(0, B_SET); step(0, 0);
        om0 = bus.mux_outmode;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, B_IS);
            if (bus.inc_pulse) cnt++;
        end
        check("inc_pulse_count_run", cnt, 0);
        check("outmode_flipped_once", {31'd0, bus.mux_outmode}, {31'd0, ~om0});

        rb = 0;
        for (int blk = 0; blk < 60; blk++) begin
            quiet = $urandom_range(0, 3);
            for (int i = 0; i < 64; i++) begin
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, (quiet == 0) ? 60 : 5) == 0) rb[k] = ~rb[k];
                step($urandom_range(0, 499) == 0, rb);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
